multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM for the multi-cycle 16-bit CPU. It sequences one shared ALU, the instruction register, the PC and a single instruction/data memory port through fetch, decode, execute, memory and write-back. It drives the 2-bit ALUOp consumed by the ALU control decoder and waits on a memory ready handshake. It sits between the instruction register (Opcode/Funct fields) and the datapath muxes and write strobes.

## Interface
- MOD_LATENCY, 4, EXEC cycles for MOD (Funct 4'b0010) when MOD_WAIT_EN is defined; legal range 1..15
- Clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high
- Opcode  in  3  IR[15:13]: 000 R, 001 ANDI, 010 ORI, 011 ADDI, 100 SLTI, 101 LW, 110 SW, 111 BNE
- Funct  in  4  IR R-format function field
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current read/write this cycle
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  strobes
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = memory data to register file
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = const 2, 10 = sign-ext imm, 11 = sign-ext imm<<1
- ALUOp  out  2  00 add, 01 subtract/compare, 10 R-format, 11 I-format
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- State  out  3  current state encoding, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5. Codes 6 and 7 are illegal and go to FETCH on the next edge with all strobes 0.
- Outputs are combinational from the state and the latched Opcode/Funct (OpReg/FnReg, captured on the DECODE->next edge). Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - While MemReady=0, stay in FETCH.
  - When MemReady=1, IRWrite=1 and PCWrite=1 (PCSource=0), then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Latch Opcode/Funct.
  - Next state: 111 -> BRANCH, all others -> EXEC.
- EXEC: ALUSrcA=1.
  - R: ALUSrcB=00, ALUOp=10.
  - I (001-100): ALUSrcB=10, ALUOp=11.
  - LW/SW: ALUSrcB=10, ALUOp=00.
  - Next state: LW/SW -> MEM, others -> WB.
- MEM: MemRead=1 for LW, MemWrite=1 for SW.
  - Hold while MemReady=0.
  - On MemReady=1: LW -> WB, SW -> FETCH.
- WB: RegWrite=1; RegDst=1 only for R; MemToReg=1 only for LW. Next state FETCH.
- BRANCH (BNE): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=!Zero. Next state FETCH.

## Timing
- Reset: on the edge with Reset=1, state becomes FETCH, the MOD counter clears and OpReg/FnReg clear to 0. While Reset=1, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are forced to 0 in the same cycle. The first fetch begins in the first cycle after Reset falls.
- Reset mid-operation (any state, including a MEM stall) aborts the instruction. No strobe is asserted in the Reset cycle, and the next state is FETCH.
- Cycles per instruction with zero memory wait: BNE 3, R/I 4, SW 4, LW 5. Each cycle MemReady=0 in FETCH or MEM adds exactly one cycle.
- IRWrite and PCWrite pulse exactly once per fetch, in the cycle MemReady=1.
- MemReady is ignored outside FETCH and MEM.
- Opcode/Funct changes after DECODE have no effect until the next DECODE.

## Configuration
- MOD_WAIT_EN defined: EXEC for R-format with FnReg=4'b0010 lasts MOD_LATENCY cycles.
  - A 4-bit down-counter loads MOD_LATENCY-1 on entry to EXEC.
  - The FSM leaves EXEC when the counter reaches 0.
  - Outputs are held constant for all EXEC cycles.
- MOD_WAIT_EN undefined: MOD takes one EXEC cycle like every other R op. The counter and the MOD_LATENCY parameter have no effect.

## Test plan
- Reset then R ADD (Opcode 000, Funct 0000), MemReady=1: State 0,1,2,4,0. In EXEC, ALUOp=10 and ALUSrcB=00. In WB, RegWrite=1 and RegDst=1. 4 cycles total.
- LW (101) with MemReady=0 for the first 2 MEM cycles: MemRead=1 for 3 MEM cycles. WB has MemToReg=1 and RegDst=0. 7 cycles total.
- BNE (111): with Zero=0, BRANCH gives PCWrite=1, PCSource=1, ALUOp=01. Repeat with Zero=1: PCWrite=0 and the next state is still FETCH.
- FETCH stall, MemReady=0 for 5 cycles then 1: IRWrite/PCWrite stay 0 for 5 cycles, then pulse exactly once, then DECODE.
- MOD (000/0010) with MOD_LATENCY=4: with MOD_WAIT_EN defined, EXEC lasts 4 cycles then WB. Without the macro, EXEC lasts 1 cycle.
- SW (110) with Reset asserted during a stalled MEM: MemWrite=0 in the Reset cycle, State=0 after the edge, and the next fetch starts after Reset falls.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle 16-bit CPU: fetch/decode/exec/mem/wb/branch sequencing.
// Optional macro MOD_WAIT_EN stretches EXEC of R-format MOD (Funct 4'b0010) to MOD_LATENCY cycles.
module multicycle_controller #(
    parameter int MOD_LATENCY = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_opcode,
    input  logic [3:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_pc_source,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5
    } state_t;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;
    localparam logic [3:0] MOD_LOAD = 4'(MOD_LATENCY - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [3:0] r_fn;
    logic [3:0] r_mod_cnt;
    logic       w_mod_busy;
    logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;

`ifdef MOD_WAIT_EN
    assign w_mod_busy = (r_op == OP_R) && (r_fn == 4'b0010) && (r_mod_cnt != 4'd0);
`else
    logic w_unused;
    assign w_mod_busy = 1'b0;
    assign w_unused   = ^{r_fn, r_mod_cnt};
`endif

    // State register, latched instruction fields and MOD wait counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_op      <= 3'd0;
            r_fn      <= 4'd0;
            r_mod_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= i_opcode;
                r_fn <= i_funct;
            end
            if ((r_state == S_DECODE) && (w_next == S_EXEC)) begin
                r_mod_cnt <= MOD_LOAD;
            end else if ((r_state == S_EXEC) && (r_mod_cnt != 4'd0)) begin
                r_mod_cnt <= r_mod_cnt - 4'd1;
            end
        end
    end

    // Next-state and control outputs decoded from state and latched fields
    always_comb begin
        w_next       = S_FETCH;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_pc_source  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
                w_next      = (i_opcode == OP_BNE) ? S_BRANCH : S_EXEC;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                if (r_op == OP_R) begin
                    o_alu_src_b = 2'b00;
                    o_alu_op    = 2'b10;
                end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
                    o_alu_src_b = 2'b10;
                    o_alu_op    = 2'b00;
                end else begin
                    o_alu_src_b = 2'b10;
                    o_alu_op    = 2'b11;
                end
                if (w_mod_busy) begin
                    w_next = S_EXEC;
                end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_read  = (r_op == OP_LW);
                w_mem_write = (r_op == OP_SW);
                if (!i_mem_ready) begin
                    w_next = S_MEM;
                end else if (r_op == OP_LW) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                o_reg_dst    = (r_op == OP_R);
                o_mem_to_reg = (r_op == OP_LW);
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b00;
                o_alu_op    = 2'b01;
                o_pc_source = 1'b1;
                w_pc_write  = ~i_zero;
                w_next      = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are suppressed for the whole reset cycle so an aborted access never writes
    assign o_pc_write  = w_pc_write  & ~i_reset;
    assign o_ir_write  = w_ir_write  & ~i_reset;
    assign o_mem_read  = w_mem_read  & ~i_reset;
    assign o_mem_write = w_mem_write & ~i_reset;
    assign o_reg_write = w_reg_write & ~i_reset;
    assign o_state     = r_state;

endmodule
